// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx parallel-in/serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Width of the bit counter needed to count W-1 down to 0.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Load-side and serial-side signals of piso_tx grouped as one bus.
// Handshake: a word transfers on a cycle with load_valid_i & load_ready_o; a serial
// bit transfers on a cycle with x_valid_o & shift_en_i; x_o is held while not consumed.
interface piso_tx_if #(
  parameter int W = 4
);
  logic         load_valid_i;
  logic [W-1:0] load_data_i;
  logic         load_ready_o;
  logic         shift_en_i;
  logic         x_o;
  logic         x_valid_o;
  logic         last_o;
  logic         busy_o;

  modport master (
    output load_valid_i, load_data_i, shift_en_i,
    input  load_ready_o, x_o, x_valid_o, last_o, busy_o
  );

  modport slave (
    input  load_valid_i, load_data_i, shift_en_i,
    output load_ready_o, x_o, x_valid_o, last_o, busy_o
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in, serial-out shifter: accepts a W-bit word on a valid/ready load and
// sends it MSB first, reloading back-to-back on the last-bit cycle when a word waits.
module piso_tx
  import piso_pkg::*;
#(
  parameter int W = 4
) (
  input  logic        clk,
  input  logic        reset,
  piso_tx_if.slave    bus,
  output piso_state_t state_dbg
);

  localparam int            CW      = cnt_w(W);
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  piso_state_t   state_ff, nxt_state;
  logic [W-1:0]  sr_ff, nxt_sr;
  logic [CW-1:0] cnt_ff, nxt_cnt;

  logic load_ready;
  logic x;
  logic x_valid;
  logic last;
  logic busy;

  always_comb begin
    nxt_state  = state_ff;
    nxt_sr     = sr_ff;
    nxt_cnt    = cnt_ff;
    load_ready = 1'b0;
    x_valid    = 1'b0;
    x          = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    case (state_ff)
      IDLE: begin
        load_ready = 1'b1;
        if (bus.load_valid_i) begin
          nxt_sr    = bus.load_data_i;
          nxt_cnt   = CNT_TOP;
          nxt_state = SHIFT;
        end
      end
      SHIFT: begin
        x_valid    = 1'b1;
        busy       = 1'b1;
        x          = sr_ff[W-1];
        last       = (cnt_ff == '0);
        load_ready = last & bus.shift_en_i;
        if (bus.shift_en_i) begin
          if (!last) begin
            nxt_sr  = {sr_ff[W-2:0], 1'b0};
            nxt_cnt = cnt_ff - CW'(1);
          end else if (bus.load_valid_i) begin
            // Next word follows the current LSB with no idle bubble.
            nxt_sr  = bus.load_data_i;
            nxt_cnt = CNT_TOP;
          end else begin
            nxt_state = IDLE;
            nxt_sr    = '0;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_ff <= IDLE;
    else       state_ff <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (reset) sr_ff <= '0;
    else       sr_ff <= nxt_sr;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_ff <= '0;
    else       cnt_ff <= nxt_cnt;
  end

  // Outputs read as idle for the whole time reset is asserted, even mid-word.
  assign bus.load_ready_o = load_ready & ~reset;
  assign bus.x_o          = x & ~reset;
  assign bus.x_valid_o    = x_valid & ~reset;
  assign bus.last_o       = last & ~reset;
  assign bus.busy_o       = busy & ~reset;
  assign state_dbg        = state_ff;

endmodule

// File: tb/tb_piso_tx.sv
// Directed and random checks of piso_tx against a bit/word scoreboard and a 4-bit SIPO receiver.
module tb_piso_tx;
  import piso_pkg::*;

  localparam int W = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  piso_state_t state_dbg;

  piso_tx_if #(.W(W)) bus ();

  piso_tx #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference receiver ----------------
  logic [W-1:0] sipo;
  always @(posedge clk) begin
    if (reset)                              sipo <= '0;
    else if (bus.x_valid_o && bus.shift_en_i) sipo <= {sipo[W-2:0], bus.x_o};
  end

  // ---------------- scoreboard ----------------
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   bit_q[$];
  logic [W-1:0] sipo_exp;
  logic         sipo_pend = 1'b0;
  logic         hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  task automatic sb_eval();
    logic [1:0] e;
    hs = 1'b0;
    if (sipo_pend) begin
      chk("sipo_word", sipo, sipo_exp);
      sipo_pend = 1'b0;
    end
    if (bus.load_valid_i && bus.load_ready_o) begin
      hs = 1'b1;
      exp_q.push_back(bus.load_data_i);
      for (int i = W - 1; i >= 0; i--) bit_q.push_back({bus.load_data_i[i], i == 0});
    end
    if (bus.x_valid_o) begin
      if (bus.shift_en_i) begin
        if (bit_q.size() == 0) begin
          chk("unexpected_bit", bus.x_valid_o, 0);
        end else begin
          e = bit_q.pop_front();
          chk("serial_bit", bus.x_o, e[1]);
          chk("last_flag", bus.last_o, e[0]);
          if (e[0] && exp_q.size() > 0) begin
            sipo_exp  = exp_q.pop_front();
            sipo_pend = 1'b1;
          end
        end
      end else if (bit_q.size() > 0) begin
        chk("stall_hold", bus.x_o, bit_q[0][1]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic lv, input logic [W-1:0] ld, input logic se);
    @(posedge clk);
    #1;
    reset            = rst;
    bus.load_valid_i = lv;
    bus.load_data_i  = ld;
    bus.shift_en_i   = se;
    cyc++;
    #1;
    sb_eval();
    if (rst) begin
      exp_q.delete();
      bit_q.delete();
      sipo_pend = 1'b0;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bus.x_valid_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] w;
    logic [7:0]   seq;
    int           start;
    int           n;

    bus.load_valid_i = 1'b0;
    bus.load_data_i  = '0;
    bus.shift_en_i   = 1'b0;

    // Reset held two cycles with a producer already offering a word.
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'h7, 1'b1);
      chk("rst_ready", bus.load_ready_o, 0);
      chk("rst_x", bus.x_o, 0);
      chk("rst_last", bus.last_o, 0);
      chk_idle("rst");
    end

    // Test 1: single word 1011.
    w = 4'b1011;
    step(1'b0, 1'b1, w, 1'b1);
    chk("t1_ready", bus.load_ready_o, 1);
    chk_idle("t1_load");
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("t1_x", bus.x_o, w[4-i]);
      chk("t1_last", bus.last_o, i == 4);
      chk("t1_busy", bus.busy_o, 1);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t1_end");

    // Test 2: back-to-back A then 5.
    seq = 8'hA5;
    step(1'b0, 1'b1, 4'hA, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, i <= 4, 4'h5, 1'b1);
      chk("t2_valid", bus.x_valid_o, 1);
      chk("t2_x", bus.x_o, seq[8-i]);
      chk("t2_ready", bus.load_ready_o, (i == 4) || (i == 8));
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t2_end");

    // Test 3: 3-cycle stall after the first bit of C.
    w = 4'hC;
    step(1'b0, 1'b1, w, 1'b1);
    start = cyc;
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t3_x_first", bus.x_o, 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b0);
      chk("t3_stall_x", bus.x_o, 1);
      chk("t3_stall_valid", bus.x_valid_o, 1);
      chk("t3_stall_last", bus.last_o, 0);
    end
    for (int i = 2; i >= 0; i--) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("t3_x", bus.x_o, w[i]);
    end
    chk("t3_len", cyc - start, 7);
    chk("t3_last", bus.last_o, 1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t3_end");

    // Test 4: producer offers 6 while 9 is in flight.
    w = 4'h9;
    step(1'b0, 1'b1, w, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 4'h6, 1'b1);
      chk("t4_x", bus.x_o, w[4-i]);
      chk("t4_ready", bus.load_ready_o, i == 4);
    end
    w = 4'h6;
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("t4_x2", bus.x_o, w[4-i]);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t4_end");

    // Test 5: reset after two bits of F.
    step(1'b0, 1'b1, 4'hF, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b1, 1'b0, 4'h0, 1'b1);
    chk("t5_rst_valid", bus.x_valid_o, 0);
    chk("t5_rst_ready", bus.load_ready_o, 0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t5_after");
    chk("t5_sr", dut.sr_ff, 0);
    chk("t5_ready", bus.load_ready_o, 1);
    w = 4'h3;
    step(1'b0, 1'b1, w, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b0, 4'h0, 1'b1);
      chk("t5_x", bus.x_o, w[4-i]);
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    chk_idle("t5_end");

    // Test 6: 16 random words with random serial-side stalls, checked through the SIPO.
    for (int k = 0; k < 16; k++) begin
      w = 4'($urandom_range(0, 15));
      n = 0;
      do begin
        step(1'b0, 1'b1, w, $urandom_range(0, 3) != 0);
        n++;
      end while (!hs && n < 50);
      if (!hs) chk("t6_accept_timeout", hs, 1);
    end
    n = 0;
    while ((bit_q.size() > 0 || sipo_pend) && n < 400) begin
      step(1'b0, 1'b0, 4'h0, $urandom_range(0, 3) != 0);
      n++;
    end
    chk("t6_drained", bit_q.size(), 0);
    chk("t6_words_left", exp_q.size(), 0);
    chk("t6_state", state_dbg, IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
